lcd_write_arbiter: RTL and testbench

- Shares the single Avalon-MM write port of the character-LCD controller between N_REQ requesters, e.g. a status-line writer and a menu/text writer.
- Each requester submits a message: a burst of beats, each carrying an address bit (0 = control instruction, 1 = ASCII data) and a data byte, with the final beat flagged by req_last.
- Grant is round-robin and locked for a whole message, so instructions and characters from different requesters never interleave.
- Sits between the text-generation logic and the LCD Avalon slave.

---
 rtl/lcd_write_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: message-locked round-robin sharing of the
// character-LCD Avalon-MM write port between N_REQ requesters.
module lcd_write_arbiter #(
    parameter int N_REQ         = 2,
    parameter int GAP_CYCLES    = 4,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_address,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               address,
    output logic               chipselect,
    output logic               byteenable,
    output logic               read,
    output logic               write,
    output logic [7:0]         writedata,
    input  logic               waitrequest,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        NEXT,
        GAP
    } state_t;

    localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0] GRANT_RST = 2'(N_REQ - 1);

    state_t        state;
    state_t        state_next;
    state_t        end_state;

    logic [1:0]    grant_q;
    logic [1:0]    winner;
    logic [1:0]    sel;
    logic          found;
    logic          any_valid;
    logic          gvalid;
    logic          go;
    logic          stall_expired;

    logic          cap_addr;
    logic [7:0]    cap_data;
    logic          cap_last;

    logic          addr_q;
    logic [7:0]    data_q;
    logic          last_q;
    logic          write_q;
    logic          timeout_q;

    logic [SW-1:0] stall_cnt;
    logic [GW-1:0] gap_cnt;

    assign any_valid = |req_valid;
    assign end_state = (GAP_CYCLES == 0) ? IDLE : GAP;

    // Round-robin pick: first valid index after the last grant.
    always_comb begin
        winner = grant_q;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] &&
                    ((int'(grant_q) + k) % N_REQ) == i) begin
                    found  = 1'b1;
                    winner = 2'(i);
                end
            end
        end
    end

    // Valid bit of the requester currently holding the grant.
    always_comb begin
        gvalid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == 2'(i)) begin
                gvalid = req_valid[i];
            end
        end
    end

    // Beat mux for the requester selected this cycle.
    always_comb begin
        cap_addr = 1'b0;
        cap_data = 8'h00;
        cap_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == 2'(i)) begin
                cap_addr = req_address[i];
                cap_data = req_data[8*i +: 8];
                cap_last = req_last[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next    = state;
        stall_expired = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!waitrequest) begin
                    if (last_q) begin
                        state_next = end_state;
                    end else if (!gvalid) begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (gvalid) begin
                    state_next = ISSUE;
                end else if (stall_cnt == STALL_LAST) begin
                    stall_expired = 1'b1;
                    state_next    = end_state;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs: one ready bit, only for the grant holder.
    always_comb begin
        go  = 1'b0;
        sel = grant_q;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    go  = any_valid;
                    sel = winner;
                end
                ISSUE:   go = !waitrequest && !last_q && gvalid;
                NEXT:    go = gvalid;
                default: go = 1'b0;
            endcase
        end
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = go && (sel == 2'(i));
        end
    end

    // Beat capture, grant bookkeeping and registered bus controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= 1'b0;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            write_q   <= 1'b0;
            timeout_q <= 1'b0;
            grant_q   <= GRANT_RST;
        end else begin
            write_q   <= (state_next == ISSUE);
            timeout_q <= stall_expired;
            if (go) begin
                addr_q <= cap_addr;
                data_q <= cap_data;
                last_q <= cap_last;
            end
            if (state == IDLE && go) begin
                grant_q <= winner;
            end
        end
    end

    // Stall counter runs only while parked in NEXT; gap counter in GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if (state == NEXT && state_next == NEXT) begin
                stall_cnt <= stall_cnt + SW'(1);
            end else begin
                stall_cnt <= '0;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    assign address     = addr_q;
    assign writedata   = data_q;
    assign write       = write_q;
    assign chipselect  = write_q;
    assign byteenable  = write_q;
    assign read        = 1'b0;
    assign grant_id    = grant_q;
    assign busy        = (state != IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed scenarios with randomized payloads
// and stalls, checked against a message-level arbitration model.
module tb_lcd_write_arbiter;

    localparam int N   = 2;
    localparam int GAP = 4;
    localparam int STO = 255;

    typedef struct packed {
        logic       a;
        logic [7:0] d;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic       a;
        logic [7:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_address = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic         address;
    logic         chipselect;
    logic         byteenable;
    logic         read;
    logic         write;
    logic [7:0]   writedata;
    logic         waitrequest = 1'b0;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    lcd_write_arbiter #(
        .N_REQ(N),
        .GAP_CYCLES(GAP),
        .STALL_TIMEOUT(STO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_address(req_address),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .address(address),
        .chipselect(chipselect),
        .byteenable(byteenable),
        .read(read),
        .write(write),
        .writedata(writedata),
        .waitrequest(waitrequest),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    beat_t q0[$];
    beat_t q1[$];
    wr_t   e0[$];
    wr_t   e1[$];
    wr_t   expq[$];
    wr_t   obs[$];
    int    obs_cyc[$];
    bit    busy_h[$];
    bit    write_h[$];
    logic [N-1:0] ready_h[$];

    int cyc = 0;
    int owner = -1;
    int to_count = 0;
    int to_cyc = -1;
    int first_hs = -1;
    int m_last = N - 1;
    int hold[N];
    int popped[N];
    int pause_at[N];
    int pause_len[N];
    bit stall_mode = 1'b0;
    bit force_wait = 1'b0;
    bit prev_wr = 1'b0;
    bit prev_wait = 1'b0;
    logic [8:0] prev_aw = '0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int rr_pick(int last, bit [N-1:0] pend);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_tb();
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
        expq.delete(); obs.delete(); obs_cyc.delete();
        for (int i = 0; i < N; i++) begin
            hold[i] = 0; popped[i] = 0;
            pause_at[i] = -1; pause_len[i] = 0;
        end
        owner = -1; to_count = 0; to_cyc = -1; first_hs = -1;
        prev_wr = 1'b0; prev_wait = 1'b0;
        stall_mode = 1'b0; force_wait = 1'b0;
        req_valid = '0; req_address = '0; req_last = '0; req_data = '0;
        waitrequest = 1'b0;
        m_last = N - 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_tb();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push(int r, logic a, logic [7:0] d, logic last);
        beat_t b;
        wr_t   w;
        b.a = a; b.d = d; b.last = last;
        w.id = 2'(r); w.a = a; w.d = d;
        if (r == 0) begin q0.push_back(b); e0.push_back(w); end
        else begin q1.push_back(b); e1.push_back(w); end
    endtask

    task automatic push_rand(int r, int n);
        for (int i = 0; i < n; i++) begin
            push(r, 1'($urandom_range(0, 1)),
                 8'($urandom_range(32, 126)), i == n - 1);
        end
    endtask

    task automatic flush_exp(int r);
        if (r == 0) while (e0.size() > 0) expq.push_back(e0.pop_front());
        else        while (e1.size() > 0) expq.push_back(e1.pop_front());
    endtask

    // Both requesters stay pending until served: order by round robin.
    task automatic model_pair();
        bit [N-1:0] pend;
        int w;
        pend = '1;
        while (pend != 0) begin
            w = rr_pick(m_last, pend);
            flush_exp(w);
            pend[w] = 1'b0;
            m_last = w;
        end
    endtask

    task automatic cycle();
        beat_t b;
        logic [N-1:0] own_m;
        @(negedge clk);
        req_valid = '0; req_address = '0; req_last = '0; req_data = '0;
        if (q0.size() > 0 && hold[0] == 0) begin
            b = q0[0];
            req_valid[0] = 1'b1; req_address[0] = b.a;
            req_data[7:0] = b.d; req_last[0] = b.last;
        end
        if (q1.size() > 0 && hold[1] == 0) begin
            b = q1[0];
            req_valid[1] = 1'b1; req_address[1] = b.a;
            req_data[15:8] = b.d; req_last[1] = b.last;
        end
        for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
        waitrequest = stall_mode ? ($urandom_range(0, 7) < 3) : force_wait;
        #1;
        busy_h.push_back(busy);
        write_h.push_back(write);
        ready_h.push_back(req_ready);
        check("ready_onehot", $countones(req_ready) <= 1, 1);
        if (owner >= 0) begin
            own_m = '0;
            own_m[owner] = 1'b1;
            check("ready_owner", req_ready & ~own_m, 0);
        end
        if (prev_wr && prev_wait) begin
            check("hold_write", write, 1);
            check("hold_beat", {address, writedata}, prev_aw);
        end
        prev_wr = write;
        prev_wait = waitrequest;
        prev_aw = {address, writedata};
        if (write && !waitrequest) begin
            obs.push_back(wr_t'({grant_id, address, writedata}));
            obs_cyc.push_back(cyc);
        end
        if (timeout_err) begin
            to_count++;
            to_cyc = cyc;
            owner = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (i == 0) b = q0.pop_front();
                else        b = q1.pop_front();
                popped[i]++;
                if (first_hs < 0) first_hs = cyc;
                if (owner < 0) owner = i;
                if (b.last) owner = -1;
                if (popped[i] == pause_at[i]) hold[i] = pause_len[i];
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(string tag, int budget);
        int quiet;
        bit done;
        quiet = 0;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (q0.size() == 0 && q1.size() == 0 && !busy && !write)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 2) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic check_sb(string tag);
        check({tag, "_count"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            check(tag, obs[i], expq[i]);
        end
        obs.delete();
        obs_cyc.delete();
        expq.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int L;
        bit ok;
        int wcnt;

        clear_tb();
        reset = 1'b0;
        req_valid = '1;
        req_last = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_write", write, 0);
        check("rst_cs", chipselect, 0);
        check("rst_be", byteenable, 0);
        check("rst_read", read, 0);
        check("rst_addr", address, 0);
        check("rst_data", writedata, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_grant", grant_id, N - 1);
        @(negedge clk);
        clear_tb();
        reset = 1'b1;

        // Single 3-beat message "\x38 H i" on requester 0.
        push(0, 1'b0, 8'h38, 1'b0);
        push(0, 1'b1, 8'h48, 1'b0);
        push(0, 1'b1, 8'h69, 1'b1);
        flush_exp(0);
        run_until_idle("single", 40);
        if (obs_cyc.size() == 3) begin
            L = obs_cyc[2];
            check("single_latency", obs_cyc[0], first_hs + 1);
            check("single_consec", obs_cyc[2] - obs_cyc[0], 2);
            wcnt = 0;
            for (int k = first_hs; k < write_h.size(); k++) wcnt += write_h[k];
            check("single_wcount", wcnt, 3);
            ok = 1'b1;
            for (int k = 1; k <= GAP; k++) ok &= busy_h[L + k] & ~write_h[L + k];
            check("single_gap_busy", ok, 1);
            check("single_idle", busy_h[L + GAP + 1], 0);
        end
        check_sb("single");

        // Simultaneous requests from reset, then round robin.
        do_reset();
        push_rand(0, 2);
        push_rand(1, 3);
        model_pair();
        run_until_idle("pair1", 80);
        if (obs_cyc.size() == 5) begin
            L = obs_cyc[1];
            ok = 1'b1;
            for (int k = 1; k <= GAP; k++) ok &= (ready_h[L + k] == 0);
            check("pair1_gap_noready", ok, 1);
            check("pair1_second_grant", ready_h[L + GAP + 1], 2'b10);
        end
        check_sb("pair1");
        push_rand(0, 1);
        flush_exp(0);
        m_last = 0;
        run_until_idle("solo0", 40);
        check_sb("solo0");
        push_rand(0, 2);
        push_rand(1, 2);
        model_pair();
        run_until_idle("pair2", 80);
        check_sb("pair2");
        check("pair2_grant", grant_id, m_last);

        // 16 characters on requester 1 under random waitrequest.
        stall_mode = 1'b1;
        push_rand(1, 16);
        flush_exp(1);
        run_until_idle("stall16", 400);
        stall_mode = 1'b0;
        check_sb("stall16");

        // Requester 0 pauses 10 cycles between beats 2 and 3.
        do_reset();
        pause_at[0] = 2;
        pause_len[0] = 10;
        push_rand(0, 3);
        push_rand(1, 1);
        flush_exp(0);
        flush_exp(1);
        run_until_idle("midgap", 100);
        if (obs_cyc.size() == 4) begin
            check("midgap_spacing", obs_cyc[2] - obs_cyc[1], 11);
        end
        check_sb("midgap");

        // Requester 0 stalls 300 cycles after beat 1: grant revoked.
        do_reset();
        pause_at[0] = 1;
        pause_len[0] = 300;
        push_rand(0, 3);
        push_rand(1, 2);
        expq.push_back(e0.pop_front());
        flush_exp(1);
        flush_exp(0);
        run_until_idle("timeout", 800);
        check("timeout_pulses", to_count, 1);
        if (obs_cyc.size() == 5) begin
            check("timeout_delay", to_cyc - obs_cyc[0], STO + 1);
            check("timeout_regrant", obs_cyc[1], to_cyc + GAP + 1);
        end
        check_sb("timeout");

        // Reset while a write is stalled.
        do_reset();
        force_wait = 1'b1;
        push_rand(0, 4);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (write) break;
        end
        cycle();
        cycle();
        check("midrst_pre_write", write, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_write", write, 0);
        check("midrst_cs", chipselect, 0);
        check("midrst_be", byteenable, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        clear_tb();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_grant", grant_id, N - 1);
        push_rand(1, 2);
        push_rand(0, 1);
        model_pair();
        run_until_idle("midrst", 80);
        check_sb("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
